// File: rtl/rv32m_div_sequencer.sv
// Issuing side of the RV32M divide path: resolves divide-by-zero, signed overflow and
// cached results locally, otherwise runs the external divider and returns the selected result.
module rv32m_div_sequencer #(
    parameter int NUM_BITS = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_funct,
    input  logic [NUM_BITS-1:0] req_rs1,
    input  logic [NUM_BITS-1:0] req_rs2,
    input  logic                flush,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [NUM_BITS-1:0] resp_data,
    output logic                div_start,
    output logic                div_is_signed,
    output logic [NUM_BITS-1:0] div_dividend,
    output logic [NUM_BITS-1:0] div_divisor,
    input  logic [NUM_BITS-1:0] div_quotient,
    input  logic [NUM_BITS-1:0] div_remainder,
    input  logic                div_finished
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [NUM_BITS-1:0] MIN_NEG = {1'b1, {(NUM_BITS-1){1'b0}}};

    state_t state, state_next;

    logic                sel_quot;
    logic                cache_valid;
    logic                cache_signed;
    logic [NUM_BITS-1:0] cache_rs1;
    logic [NUM_BITS-1:0] cache_rs2;
    logic [NUM_BITS-1:0] cache_quot;
    logic [NUM_BITS-1:0] cache_rem;

    logic                accept;
    logic                req_signed;
    logic                req_quot;
    logic                is_zero;
    logic                is_ovf;
    logic                is_hit;
    logic                is_early;
    logic [NUM_BITS-1:0] early_data;

    function automatic logic [NUM_BITS-1:0] select_result(
        input logic                want_quot,
        input logic [NUM_BITS-1:0] quot,
        input logic [NUM_BITS-1:0] rem
    );
        return want_quot ? quot : rem;
    endfunction

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_DONE);
    assign div_start  = (state == S_ISSUE);

    // Accept-cycle classification; flush suppresses the accept entirely
    always_comb begin
        accept     = req_valid && (state == S_IDLE) && !flush;
        req_signed = ~req_funct[0];
        req_quot   = ~req_funct[1];
        is_zero    = (req_rs2 == '0);
        is_ovf     = req_signed && (req_rs1 == MIN_NEG) && (req_rs2 == '1);
        is_hit     = cache_valid && (cache_rs1 == req_rs1) && (cache_rs2 == req_rs2)
                     && (cache_signed == req_signed);
        is_early   = is_zero || is_ovf || is_hit;
        early_data = '0;
        if (is_zero) begin
            early_data = select_result(req_quot, '1, req_rs1);
        end else if (is_ovf) begin
            early_data = select_result(req_quot, req_rs1, '0);
        end else if (is_hit) begin
            early_data = select_result(req_quot, cache_quot, cache_rem);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = is_early ? S_DONE : S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (div_finished) state_next = S_DONE;
            S_DONE:  if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    // Operand capture, result register and one-entry result cache
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            div_dividend  <= '0;
            div_divisor   <= '0;
            div_is_signed <= 1'b0;
            sel_quot      <= 1'b0;
            resp_data     <= '0;
            cache_valid   <= 1'b0;
            cache_signed  <= 1'b0;
            cache_rs1     <= '0;
            cache_rs2     <= '0;
            cache_quot    <= '0;
            cache_rem     <= '0;
        end else begin
            if (accept) begin
                div_dividend  <= req_rs1;
                div_divisor   <= req_rs2;
                div_is_signed <= req_signed;
                sel_quot      <= req_quot;
                if (is_early) resp_data <= early_data;
            end
            if ((state == S_WAIT) && div_finished && !flush) begin
                resp_data    <= select_result(sel_quot, div_quotient, div_remainder);
                cache_valid  <= 1'b1;
                cache_signed <= div_is_signed;
                cache_rs1    <= div_dividend;
                cache_rs2    <= div_divisor;
                cache_quot   <= div_quotient;
                cache_rem    <= div_remainder;
            end
            if (flush) cache_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32m_div_sequencer.sv
// Bench for rv32m_div_sequencer: behavioural radix-4 divider timing model plus a
// scoreboard of expected results and latencies popped as responses return.
module tb_rv32m_div_sequencer;

    logic        CLK;
    logic        nRST;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_funct;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        div_start;
    logic        div_is_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient = '0;
    logic [31:0] div_remainder = '0;
    logic        div_finished = 1'b0;

    int div_cnt = 0;
    int start_cnt = 0;
    int check_cnt = 0;
    int pass_cnt = 0;

    logic [31:0] exp_data_q[$];
    int          exp_lat_q[$];

    rv32m_div_sequencer #(.NUM_BITS(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .div_start(div_start), .div_is_signed(div_is_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_finished(div_finished)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Divider model: finished rises 17 edges after the start edge, cleared by start
    always @(posedge CLK) begin
        if (div_start) begin
            start_cnt    <= start_cnt + 1;
            div_cnt      <= 17;
            div_finished <= 1'b0;
            if (div_divisor == 0) begin
                div_quotient  <= '1;
                div_remainder <= div_dividend;
            end else if (div_is_signed) begin
                div_quotient  <= $signed(div_dividend) / $signed(div_divisor);
                div_remainder <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
                div_quotient  <= div_dividend / div_divisor;
                div_remainder <= div_dividend % div_divisor;
            end
        end else if (div_cnt > 0) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) div_finished <= 1'b1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
        if (!f[0]) return f[1] ? sa % sb : sa / sb;
        return f[1] ? a % b : a / b;
    endfunction

    // Drives one request, waits (bounded) for the response, optionally stalls resp_ready
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] data, output int lat,
                          output int starts, output int start_at, output bit held_ok);
        int s0;
        @(negedge CLK);
        s0 = start_cnt;
        req_valid = 1'b1;
        req_funct = f;
        req_rs1   = a;
        req_rs2   = b;
        @(negedge CLK);
        req_valid = 1'b0;
        lat      = 1;
        start_at = -1;
        while (!resp_valid && lat < 60) begin
            if (div_start && start_at < 0) start_at = lat;
            @(negedge CLK);
            lat++;
        end
        if (!resp_valid) lat = -1;
        data    = resp_data;
        held_ok = 1'b1;
        repeat (hold) begin
            @(negedge CLK);
            if (resp_valid !== 1'b1 || resp_data !== data || req_ready !== 1'b0) held_ok = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge CLK);
        resp_ready = 1'b0;
        starts = start_cnt - s0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #1;
        check_cnt++;
        if ({req_ready, resp_valid, div_start} !== 3'b100) $display("FAIL reset_ctrl: got %b, required 100", {req_ready, resp_valid, div_start});
        else pass_cnt++;
        check_cnt++;
        if (resp_data !== 32'h0) $display("FAIL reset_data: got %h, required 0", resp_data);
        else pass_cnt++;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_divu_hit();
        logic [31:0] d, ed;
        int l, s, sa, el;
        bit h;
        exp_data_q.push_back(32'd14); exp_lat_q.push_back(20);
        exp_data_q.push_back(32'd2);  exp_lat_q.push_back(1);
        run_op(2'b01, 32'd100, 32'd7, 0, d, l, s, sa, h);
        ed = exp_data_q.pop_front(); el = exp_lat_q.pop_front();
        check_cnt++;
        if (d !== ed || l !== el) $display("FAIL divu_100_7: got %h lat %0d, required %h lat %0d", d, l, ed, el);
        else pass_cnt++;
        check_cnt++;
        if (s !== 1 || sa !== 1) $display("FAIL divu_start: got %0d pulses at cycle %0d, required 1 at 1", s, sa);
        else pass_cnt++;
        run_op(2'b11, 32'd100, 32'd7, 0, d, l, s, sa, h);
        ed = exp_data_q.pop_front(); el = exp_lat_q.pop_front();
        check_cnt++;
        if (d !== ed || l !== el || s !== 0) $display("FAIL remu_hit: got %h lat %0d starts %0d, required %h lat %0d starts 0", d, l, s, ed, el);
        else pass_cnt++;
    endtask

    task automatic test_signed_cache();
        logic [1:0]  f[3] = '{2'b00, 2'b10, 2'b11};
        logic [31:0] e[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h1};
        int          el[3] = '{20, 1, 20};
        int          es[3] = '{1, 0, 1};
        logic [31:0] d, ed;
        int l, s, sa, xl;
        bit h;
        for (int i = 0; i < 3; i++) begin
            exp_data_q.push_back(e[i]);
            exp_lat_q.push_back(el[i]);
        end
        for (int i = 0; i < 3; i++) begin
            run_op(f[i], 32'hFFFF_FFF9, 32'd2, 0, d, l, s, sa, h);
            ed = exp_data_q.pop_front(); xl = exp_lat_q.pop_front();
            check_cnt++;
            if (d !== ed || l !== xl || s !== es[i]) $display("FAIL signed_cache[%0d]: got %h lat %0d starts %0d, required %h lat %0d starts %0d", i, d, l, s, ed, xl, es[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  f[3] = '{2'b00, 2'b10, 2'b01};
        logic [31:0] a[3] = '{32'd5, 32'd5, 32'd0};
        logic [31:0] e[3] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
        logic [31:0] d, ed;
        int l, s, sa, xl;
        bit h;
        for (int i = 0; i < 3; i++) begin
            exp_data_q.push_back(e[i]);
            exp_lat_q.push_back(1);
        end
        for (int i = 0; i < 3; i++) begin
            run_op(f[i], a[i], 32'd0, 0, d, l, s, sa, h);
            ed = exp_data_q.pop_front(); xl = exp_lat_q.pop_front();
            check_cnt++;
            if (d !== ed || l !== xl || s !== 0) $display("FAIL div_zero[%0d]: got %h lat %0d starts %0d, required %h lat %0d starts 0", i, d, l, s, ed, xl);
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        logic [1:0]  f[2] = '{2'b00, 2'b10};
        logic [31:0] e[2] = '{32'h8000_0000, 32'h0};
        logic [31:0] d, ed;
        int l, s, sa, xl;
        bit h;
        for (int i = 0; i < 2; i++) begin
            exp_data_q.push_back(e[i]);
            exp_lat_q.push_back(1);
        end
        for (int i = 0; i < 2; i++) begin
            run_op(f[i], 32'h8000_0000, 32'hFFFF_FFFF, 0, d, l, s, sa, h);
            ed = exp_data_q.pop_front(); xl = exp_lat_q.pop_front();
            check_cnt++;
            if (d !== ed || l !== xl || s !== 0) $display("FAIL overflow[%0d]: got %h lat %0d starts %0d, required %h lat %0d starts 0", i, d, l, s, ed, xl);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        logic [31:0] d, ed;
        int l, s, sa, xl;
        bit h, seen;
        @(negedge CLK);
        req_valid = 1'b1; req_funct = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd3;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check_cnt++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL flush_idle: got ready %b valid %b, required 1 0", req_ready, resp_valid);
        else pass_cnt++;
        seen = 1'b0;
        repeat (25) begin
            @(negedge CLK);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        check_cnt++;
        if (seen !== 1'b0) $display("FAIL flush_no_resp: got resp_valid seen %b, required 0", seen);
        else pass_cnt++;
        exp_data_q.push_back(32'd333); exp_lat_q.push_back(20);
        run_op(2'b01, 32'd1000, 32'd3, 0, d, l, s, sa, h);
        ed = exp_data_q.pop_front(); xl = exp_lat_q.pop_front();
        check_cnt++;
        if (d !== ed || l !== xl || s !== 1) $display("FAIL flush_rerun: got %h lat %0d starts %0d, required %h lat %0d starts 1", d, l, s, ed, xl);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        logic [31:0] d, ed;
        int l, s, sa, xl;
        bit h;
        exp_data_q.push_back(32'd142); exp_lat_q.push_back(20);
        run_op(2'b00, 32'd1000, 32'd7, 5, d, l, s, sa, h);
        ed = exp_data_q.pop_front(); xl = exp_lat_q.pop_front();
        check_cnt++;
        if (d !== ed || l !== xl) $display("FAIL backpressure_data: got %h lat %0d, required %h lat %0d", d, l, ed, xl);
        else pass_cnt++;
        check_cnt++;
        if (h !== 1'b1) $display("FAIL backpressure_hold: got held %b, required 1", h);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [1:0]  f[8];
        logic [31:0] a[8];
        logic [31:0] b[8];
        logic [31:0] d, ed;
        int l, s, sa, xl;
        bit h;
        for (int i = 0; i < 8; i++) begin
            f[i] = 2'($urandom_range(0, 3));
            a[i] = $urandom;
            b[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 28)) | 32'h1;
            exp_data_q.push_back(ref_result(f[i], a[i], b[i]));
            exp_lat_q.push_back((b[i] == 0) ? 1 : 20);
        end
        for (int i = 0; i < 8; i++) begin
            run_op(f[i], a[i], b[i], 0, d, l, s, sa, h);
            ed = exp_data_q.pop_front(); xl = exp_lat_q.pop_front();
            check_cnt++;
            if (d !== ed || l !== xl) $display("FAIL random[%0d] f%0d %h/%h: got %h lat %0d, required %h lat %0d", i, f[i], a[i], b[i], d, l, ed, xl);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] d, ed;
        int l, s, sa, xl;
        bit h;
        @(negedge CLK);
        req_valid = 1'b1; req_funct = 2'b01; req_rs1 = 32'd500; req_rs2 = 32'd9;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (4) @(negedge CLK);
        check_cnt++;
        if (div_dividend !== 32'd500 || div_divisor !== 32'd9 || div_is_signed !== 1'b0) $display("FAIL wait_operands: got %h %h %b, required 1f4 9 0", div_dividend, div_divisor, div_is_signed);
        else pass_cnt++;
        nRST = 1'b0;
        #1;
        check_cnt++;
        if ({req_ready, resp_valid, div_start, div_is_signed} !== 4'b1000 || resp_data !== 32'h0) $display("FAIL reset_in_wait_ctrl: got %b data %h, required 1000 data 0", {req_ready, resp_valid, div_start, div_is_signed}, resp_data);
        else pass_cnt++;
        check_cnt++;
        if (div_dividend !== 32'h0 || div_divisor !== 32'h0) $display("FAIL reset_in_wait_operands: got %h %h, required 0 0", div_dividend, div_divisor);
        else pass_cnt++;
        @(negedge CLK);
        nRST = 1'b1;
        exp_data_q.push_back(32'd142); exp_lat_q.push_back(20);
        run_op(2'b00, 32'd1000, 32'd7, 0, d, l, s, sa, h);
        ed = exp_data_q.pop_front(); xl = exp_lat_q.pop_front();
        check_cnt++;
        if (d !== ed || l !== xl || s !== 1) $display("FAIL reset_clears_cache: got %h lat %0d starts %0d, required %h lat %0d starts 1", d, l, s, ed, xl);
        else pass_cnt++;
    endtask

    initial begin
        req_valid  = 1'b0;
        req_funct  = 2'b00;
        req_rs1    = '0;
        req_rs2    = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_divu_hit();
        test_signed_cache();
        test_div_zero();
        test_overflow();
        test_flush();
        test_back_pressure();
        test_random();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
